// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared definitions for the instruction-fetch front end: bus widths, word
// constants, chip-enable and reset-polarity encodings, and small helpers used
// by the PC register and the IF/ID pipeline register.
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    // Bus widths
    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    // Word constants
    localparam inst_addr_t ZERO_WORD = 32'h0000_0000;
    localparam inst_addr_t PC_STEP   = 32'h0000_0004;

    // Chip enable encoding
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // Stall encoding
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Reset polarity: the core reset is active-low
    localparam logic RST_ENABLE  = 1'b0;
    localparam logic RST_DISABLE = 1'b1;

    // Source selected for the next PC value (exposed for debug/observation)
    typedef enum logic [2:0] {
        PC_SEL_HOLD   = 3'd0,
        PC_SEL_FLUSH  = 3'd1,
        PC_SEL_STALL  = 3'd2,
        PC_SEL_BRANCH = 3'd3,
        PC_SEL_SEQ    = 3'd4
    } pc_sel_e;

    // Action taken by the IF/ID register this cycle
    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_HOLD   = 2'd2,
        IFID_FLUSH  = 2'd3
    } ifid_act_e;

    // A fetch address is word-aligned when its two low bits are zero.
    function automatic logic is_misaligned(input inst_addr_t addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage : if_fetch_unit_pkg

// File: rtl/if_fetch_unit_if_id.sv
// -----------------------------------------------------------------------------
// if_id
// IF/ID pipeline register. Captures the PC and the ROM's combinational
// instruction. Flush and bubble (IF stopped while ID runs) both inject an
// invalid NOP; IF and ID both stopped holds the register. A misaligned fetch
// still advances but delivers NOP_WORD flagged with AdEL.
//
// Ports:
//   clk          core clock, rising edge
//   rst          synchronous reset, active-low
//   i_stall_if   1 = IF stage stopped
//   i_stall_id   1 = ID stage stopped
//   i_flush      exception/eret flush
//   i_pc         PC of the instruction currently in IF
//   i_ce         ROM chip enable (fetch is real when 1)
//   i_inst       ROM instruction for i_pc
//   o_id_pc      PC of instruction in IF/ID
//   o_id_inst    instruction in IF/ID
//   o_id_valid   1 = o_id_inst is a real fetched instruction
//   o_id_adel    1 = fetch address was misaligned
//   o_act        register action this cycle (observation only)
// -----------------------------------------------------------------------------
module if_id
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall_if,
    input  logic        i_stall_id,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic        i_ce,
    input  logic [31:0] i_inst,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_inst,
    output logic        o_id_valid,
    output logic        o_id_adel,
    output ifid_act_e   o_act
);

    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_id_adel;
    ifid_act_e   w_act;

    always_comb begin
        if (i_flush) begin
            w_act = IFID_FLUSH;
        end else if (i_stall_if == STOP && i_stall_id == NO_STOP) begin
            w_act = IFID_BUBBLE;
        end else if (i_stall_if == STOP) begin
            w_act = IFID_HOLD;
        end else begin
            w_act = IFID_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_id_pc    <= ZERO_WORD;
            r_id_inst  <= NOP_WORD;
            r_id_valid <= 1'b0;
            r_id_adel  <= 1'b0;
        end else begin
            case (w_act)
                IFID_FLUSH, IFID_BUBBLE: begin
                    r_id_pc    <= ZERO_WORD;
                    r_id_inst  <= NOP_WORD;
                    r_id_valid <= 1'b0;
                    r_id_adel  <= 1'b0;
                end
                IFID_HOLD: begin
                    r_id_pc    <= r_id_pc;
                    r_id_inst  <= r_id_inst;
                    r_id_valid <= r_id_valid;
                    r_id_adel  <= r_id_adel;
                end
                default: begin
                    r_id_pc    <= i_pc;
                    r_id_valid <= i_ce;
                    if (i_ce == CHIP_DISABLE) begin
                        r_id_inst <= NOP_WORD;
                        r_id_adel <= 1'b0;
                    end else if (is_misaligned(i_pc)) begin
                        // Fetch carries on; the AdEL flag lets the core raise
                        // the exception and flush later.
                        r_id_inst <= NOP_WORD;
                        r_id_adel <= 1'b1;
                    end else begin
                        r_id_inst <= i_inst;
                        r_id_adel <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_id_pc    = r_id_pc;
    assign o_id_inst  = r_id_inst;
    assign o_id_valid = r_id_valid;
    assign o_id_adel  = r_id_adel;
    assign o_act      = w_act;

endmodule : if_id

// File: rtl/if_fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter and ROM chip-enable. After reset the chip enable rises one
// cycle after reset release while the PC stays at RESET_PC, so the first real
// fetch is at RESET_PC. Once enabled, the next PC is chosen by priority:
// flush redirect, stall hold, taken branch, then sequential +4 (wraps mod 2^32).
//
// Ports:
//   clk             core clock, rising edge
//   rst             synchronous reset, active-low
//   i_stall_pc      1 = hold PC
//   i_flush         exception/eret flush
//   i_new_pc        flush redirect target
//   i_branch_flag   taken branch/jump from ID
//   i_branch_target taken target from ID
//   o_pc            current PC
//   o_ce            ROM chip enable
//   o_pc_sel        next-PC source chosen this cycle (observation only)
// -----------------------------------------------------------------------------
module pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall_pc,
    input  logic        i_flush,
    input  logic [31:0] i_new_pc,
    input  logic        i_branch_flag,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_pc,
    output logic        o_ce,
    output pc_sel_e     o_pc_sel
);

    logic [31:0] r_pc;
    logic        r_ce;
    pc_sel_e     w_pc_sel;
    logic [31:0] w_pc_next;

    // Next-PC selection. Nothing moves until the chip enable is up.
    always_comb begin
        w_pc_sel  = PC_SEL_HOLD;
        w_pc_next = r_pc;
        if (r_ce == CHIP_ENABLE) begin
            if (i_flush) begin
                w_pc_sel  = PC_SEL_FLUSH;
                w_pc_next = i_new_pc;
            end else if (i_stall_pc == STOP) begin
                // ID keeps the branch request stable, so a branch during a
                // stall is simply picked up on the first free cycle.
                w_pc_sel  = PC_SEL_STALL;
                w_pc_next = r_pc;
            end else if (i_branch_flag) begin
                w_pc_sel  = PC_SEL_BRANCH;
                w_pc_next = i_branch_target;
            end else begin
                w_pc_sel  = PC_SEL_SEQ;
                w_pc_next = r_pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_ce <= CHIP_DISABLE;
            r_pc <= RESET_PC;
        end else begin
            r_ce <= CHIP_ENABLE;
            r_pc <= w_pc_next;
        end
    end

    assign o_pc     = r_pc;
    assign o_ce     = r_ce;
    assign o_pc_sel = w_pc_sel;

endmodule : pc_reg

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end of the five-stage MIPS32 core. Drives the
// instruction ROM address/enable from the PC and captures the ROM's
// same-cycle instruction into the IF/ID register. Branches use delay-slot
// semantics: the instruction already in IF proceeds normally.
//
// Ports:
//   clk            core clock, rising edge
//   rst            synchronous reset, active-low
//   stall_pc       1 = hold PC
//   stall_if       1 = IF stage stopped
//   stall_id       1 = ID stage stopped
//   flush          exception/eret flush
//   new_pc         flush redirect target
//   branch_flag    taken branch/jump from ID
//   branch_target  taken target from ID
//   rom_inst       ROM instruction (combinational on rom_addr)
//   rom_addr       fetch address (= PC)
//   rom_ce         ROM chip enable
//   id_pc          PC of instruction in IF/ID
//   id_inst        instruction in IF/ID
//   id_valid       id_inst is a real fetched instruction
//   id_adel        fetch address misaligned, id_inst is NOP_WORD
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_pc,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic [31:0] rom_inst,
    output logic [31:0] rom_addr,
    output logic        rom_ce,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel
);

    logic [31:0] w_pc;
    logic        w_ce;
    pc_sel_e     w_pc_sel;
    ifid_act_e   w_ifid_act;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .i_stall_pc      (stall_pc),
        .i_flush         (flush),
        .i_new_pc        (new_pc),
        .i_branch_flag   (branch_flag),
        .i_branch_target (branch_target),
        .o_pc            (w_pc),
        .o_ce            (w_ce),
        .o_pc_sel        (w_pc_sel)
    );

    if_id #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .i_stall_if (stall_if),
        .i_stall_id (stall_id),
        .i_flush    (flush),
        .i_pc       (w_pc),
        .i_ce       (w_ce),
        .i_inst     (rom_inst),
        .o_id_pc    (id_pc),
        .o_id_inst  (id_inst),
        .o_id_valid (id_valid),
        .o_id_adel  (id_adel),
        .o_act      (w_ifid_act)
    );

    // The ROM indexes words by rom_addr[..:2]; the low bits pass through as-is.
    assign rom_addr = w_pc;
    assign rom_ce   = w_ce;

    // Selection codes are kept for debug probing; fold them into a dummy
    // reduction so they are not flagged as unused.
    logic w_dbg_unused;
    assign w_dbg_unused = ^{w_pc_sel, w_ifid_act};

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_pc;
    logic        stall_if;
    logic        stall_id;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] rom_inst;
    logic [31:0] rom_addr;
    logic        rom_ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;

    int total;
    int bad;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: word[n] = n + 0x100
    assign rom_inst = 32'h0000_0100 + (rom_addr >> 2);

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_pc      (stall_pc),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .flush         (flush),
        .new_pc        (new_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .rom_inst      (rom_inst),
        .rom_addr      (rom_addr),
        .rom_ce        (rom_ce),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .id_adel       (id_adel)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic        sp;
        logic        si;
        logic        sd;
        logic        fl;
        logic [31:0] npc;
        logic        br;
        logic [31:0] bt;
        logic [31:0] e_addr;
        logic        e_ce;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_valid;
        logic        e_adel;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic r, input logic sp, input logic si, input logic sd,
        input logic fl, input logic [31:0] npc, input logic br, input logic [31:0] bt,
        input logic [31:0] ea, input logic ec, input logic [31:0] ep,
        input logic [31:0] ei, input logic ev, input logic ead);
        vec_t v;
        v.rst = r; v.sp = sp; v.si = si; v.sd = sd; v.fl = fl; v.npc = npc;
        v.br = br; v.bt = bt; v.e_addr = ea; v.e_ce = ec; v.e_pc = ep;
        v.e_inst = ei; v.e_valid = ev; v.e_adel = ead;
        return v;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic drive(input logic r, input logic sp, input logic si, input logic sd,
                         input logic fl, input logic [31:0] npc,
                         input logic br, input logic [31:0] bt);
        rst = r; stall_pc = sp; stall_if = si; stall_id = sd;
        flush = fl; new_pc = npc; branch_flag = br; branch_target = bt;
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t v);
        chk("rom_addr", idx, rom_addr, v.e_addr);
        chk("rom_ce",   idx, {31'd0, rom_ce},   {31'd0, v.e_ce});
        chk("id_pc",    idx, id_pc,   v.e_pc);
        chk("id_inst",  idx, id_inst, v.e_inst);
        chk("id_valid", idx, {31'd0, id_valid}, {31'd0, v.e_valid});
        chk("id_adel",  idx, {31'd0, id_adel},  {31'd0, v.e_adel});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b0, 0, 0, 0, 0, 32'h0, 0, 32'h0);

        //                  rst sp si sd fl new_pc        br target        addr          ce id_pc         id_inst       v  adel
        vecs[0]  = mk(1'b0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[1]  = mk(1'b0, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 0);
        // release: ce rises, pc stays at RESET_PC
        vecs[2]  = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0, 0);
        vecs[3]  = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0,        32'h100,      1, 0);
        vecs[4]  = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        1, 32'h4,        32'h101,      1, 0);
        vecs[5]  = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hC,        1, 32'h8,        32'h102,      1, 0);
        vecs[6]  = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h10,       1, 32'hC,        32'h103,      1, 0);
        // full stall for three cycles at pc=0x10
        vecs[7]  = mk(1'b1, 1, 1, 1, 0, 32'h0,        0, 32'h0,        32'h10,       1, 32'hC,        32'h103,      1, 0);
        vecs[8]  = mk(1'b1, 1, 1, 1, 0, 32'h0,        0, 32'h0,        32'h10,       1, 32'hC,        32'h103,      1, 0);
        vecs[9]  = mk(1'b1, 1, 1, 1, 0, 32'h0,        0, 32'h0,        32'h10,       1, 32'hC,        32'h103,      1, 0);
        vecs[10] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h14,       1, 32'h10,       32'h104,      1, 0);
        vecs[11] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h18,       1, 32'h14,       32'h105,      1, 0);
        // bubble: IF stopped, ID running
        vecs[12] = mk(1'b1, 1, 1, 0, 0, 32'h0,        0, 32'h0,        32'h18,       1, 32'h0,        32'h0,        0, 0);
        vecs[13] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h1C,       1, 32'h18,       32'h106,      1, 0);
        // branch to 0x40, delay slot 0x1C proceeds
        vecs[14] = mk(1'b1, 0, 0, 0, 0, 32'h0,        1, 32'h40,       32'h40,       1, 32'h1C,       32'h107,      1, 0);
        vecs[15] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h44,       1, 32'h40,       32'h110,      1, 0);
        // branch held across a stall, applied on first free cycle
        vecs[16] = mk(1'b1, 1, 1, 1, 0, 32'h0,        1, 32'h80,       32'h44,       1, 32'h40,       32'h110,      1, 0);
        vecs[17] = mk(1'b1, 0, 0, 0, 0, 32'h0,        1, 32'h80,       32'h80,       1, 32'h44,       32'h111,      1, 0);
        vecs[18] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h84,       1, 32'h80,       32'h120,      1, 0);
        // flush beats branch and all stalls
        vecs[19] = mk(1'b1, 1, 1, 1, 1, 32'h180,      1, 32'h40,       32'h180,      1, 32'h0,        32'h0,        0, 0);
        vecs[20] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h184,      1, 32'h180,      32'h160,      1, 0);
        // misaligned branch target
        vecs[21] = mk(1'b1, 0, 0, 0, 0, 32'h0,        1, 32'h42,       32'h42,       1, 32'h184,      32'h161,      1, 0);
        vecs[22] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h46,       1, 32'h42,       32'h0,        1, 1);
        vecs[23] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4A,       1, 32'h46,       32'h0,        1, 1);
        // reset overrides flush and stalls
        vecs[24] = mk(1'b0, 1, 1, 1, 1, 32'h180,      1, 32'h40,       32'h0,        0, 32'h0,        32'h0,        0, 0);
        vecs[25] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h0,        32'h0,        0, 0);
        // PC wrap at the top of the address space
        vecs[26] = mk(1'b1, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h0,       32'hFFFF_FFF8, 1, 32'h0,       32'h0,        0, 0);
        vecs[27] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h4000_00FE, 1, 0);
        vecs[28] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 32'hFFFF_FFFC, 32'h4000_00FF, 1, 0);
        vecs[29] = mk(1'b1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        1, 32'h0,        32'h100,      1, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].sp, vecs[i].si, vecs[i].sd,
                  vecs[i].fl, vecs[i].npc, vecs[i].br, vecs[i].bt);
            @(posedge clk);
            #1;
            chk_all(i, vecs[i]);
        end

        // Hand sequence: reset asserted mid-stall, then release and wait
        // (bounded) for the chip enable; it must come exactly one cycle later.
        begin
            int cyc;
            logic seen;
            drive(1'b1, 1, 1, 1, 0, 32'h0, 0, 32'h0);
            @(posedge clk); #1;
            drive(1'b0, 1, 1, 1, 0, 32'h0, 0, 32'h0);
            @(posedge clk); #1;
            chk("rst_mid_stall_ce",  100, {31'd0, rom_ce}, 32'd0);
            chk("rst_mid_stall_pc",  100, id_pc, 32'h0);
            chk("rst_mid_stall_val", 100, {31'd0, id_valid}, 32'd0);
            drive(1'b1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 8) begin
                @(posedge clk); #1;
                cyc++;
                if (rom_ce) seen = 1'b1;
            end
            chk("ce_rise_latency", 101, cyc, 32'd1);
            chk("first_fetch_addr", 101, rom_addr, 32'h0);
            @(posedge clk); #1;
            chk("first_fetch_inst", 102, id_inst, 32'h100);
            chk("first_fetch_pc",   102, id_pc, 32'h0);
            chk("second_addr",      102, rom_addr, 32'h4);
        end

        // Hand sequence: flush while only IF/ID is held still clears IF/ID.
        drive(1'b1, 1, 1, 1, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk("hold_inst", 103, id_inst, 32'h100);
        drive(1'b1, 1, 1, 1, 1, 32'h200, 0, 32'h0);
        @(posedge clk); #1;
        chk("flush_in_hold_addr",  104, rom_addr, 32'h200);
        chk("flush_in_hold_valid", 104, {31'd0, id_valid}, 32'd0);
        chk("flush_in_hold_inst",  104, id_inst, 32'h0);
        drive(1'b1, 0, 0, 0, 0, 32'h0, 0, 32'h0);
        @(posedge clk); #1;
        chk("after_flush_inst", 105, id_inst, 32'h180);
        chk("after_flush_pc",   105, id_pc, 32'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_if_fetch_unit
